fifo_rd_stream: RTL and testbench

- Read-side drain stage of the asynchronous FIFO.
- Sits downstream of the read-pointer/empty logic and the dual-port memory. It generates the pop strobe (rinc), captures memory read data, and presents it as a valid/ready stream to read-domain consumers.
- A 2-entry output buffer absorbs the memory read latency and consumer back-pressure while sustaining 1 beat/cycle.

---
 rtl/fifo_rd_pkg.sv | 24 ++
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_skid2.sv | 61 ++++++
 rtl/fifo_rd_stream.sv | 91 +++++++++
 tb/tb_fifo_rd_stream.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
//------------------------------------------------------------------------------
// fifo_rd_pkg : shared types and constants for the async-FIFO read drain stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] count_t;

  localparam count_t CNT_FULL = count_t'(BUF_DEPTH);

  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  function automatic bit rd_latency_legal(input int lat);
    return (lat == RD_LAT_COMB) || (lat == RD_LAT_REG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
//------------------------------------------------------------------------------
// fifo_rd_stream_if : valid/ready output stream of the FIFO read drain stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_rd_stream_if #(
  parameter int DATASIZE = 8
);

  logic                m_valid;
  logic [DATASIZE-1:0] m_data;
  logic                m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

`default_nettype wire

// File: rtl/fifo_skid2.sv
//------------------------------------------------------------------------------
// fifo_skid2 : 2-entry registered ring buffer with simultaneous push/pop
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_skid2
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [DATASIZE-1:0] din,
  output logic [DATASIZE-1:0] dout,
  output count_t              count
);

  logic [DATASIZE-1:0] mem [BUF_DEPTH];
  logic                head;
  logic                tail;
  count_t              cnt_q;
  logic                do_push;
  logic                do_pop;

  assign do_pop  = pop & (cnt_q != '0);
  // a full buffer can still accept a beat when the head leaves in the same cycle
  assign do_push = push & ((cnt_q != CNT_FULL) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail      <= ~tail;
      end
      if (do_pop) begin
        head <= ~head;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem[head];
  assign count = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
//------------------------------------------------------------------------------
// fifo_rd_stream : async-FIFO read drain, pop strobe + 2-entry stream buffer
// Optional beat counter enabled by FIFO_RD_BEATCNT_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE   = 8,
  parameter int RD_LATENCY = 0
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic                idle,
  fifo_rd_stream_if.master    m
`ifdef FIFO_RD_BEATCNT_EN
  ,
  output logic [31:0]         beat_cnt,
  input  logic                beat_cnt_clr
`endif
);

  generate
    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
      $error("fifo_rd_stream: RD_LATENCY must be 0 or 1");
    end
  endgenerate

  count_t              count;
  logic                inflight;
  logic                push;
  logic                pop;
  logic [2:0]          credit;
  logic [DATASIZE-1:0] dout;

  assign pop    = m.m_valid & m.m_ready;
  // slots already claimed once this cycle's pop leaves; pop implies count>=1
  assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rinc   = rrst_n & ~rempty & (credit < 3'd2);

  generate
    if (RD_LATENCY == RD_LAT_REG) begin : g_lat_reg
      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          inflight <= 1'b0;
        end else begin
          inflight <= rinc;
        end
      end
      assign push = inflight;
    end else begin : g_lat_comb
      assign inflight = 1'b0;
      assign push     = rinc;
    end
  endgenerate

  fifo_skid2 #(
    .DATASIZE (DATASIZE)
  ) u_skid (
    .clk   (rclk),
    .rst_n (rrst_n),
    .push  (push),
    .pop   (pop),
    .din   (rdata),
    .dout  (dout),
    .count (count)
  );

  assign m.m_valid = (count != '0);
  assign m.m_data  = dout;
  assign idle      = (count == '0) & ~inflight & rempty;

`ifdef FIFO_RD_BEATCNT_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat_cnt <= '0;
    end else if (beat_cnt_clr) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
//------------------------------------------------------------------------------
// tb_fifo_rd_stream : directed checks of both read latencies against a FIFO model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  logic       rclk   = 1'b0;
  logic       rrst_n = 1'b0;
  logic [1:0] rdy    = 2'b00;
  logic       clr    = 1'b0;

  logic [7:0] fmem [2][32];
  logic [4:0] wptr [2];
  logic [4:0] rptr [2];

  logic       rempty0, rempty1, rinc0, rinc1, idle0, idle1;
  logic [7:0] rdata0, rdata1;
  logic [31:0] bc0, bc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 rclk = ~rclk;

  fifo_rd_stream_if #(.DATASIZE(8)) s0 ();
  fifo_rd_stream_if #(.DATASIZE(8)) s1 ();

  assign s0.m_ready = rdy[0];
  assign s1.m_ready = rdy[1];

  // upstream FIFO model: registered pointers, comb (lat 0) or registered (lat 1) read
  assign rempty0 = (rptr[0] == wptr[0]);
  assign rempty1 = (rptr[1] == wptr[1]);
  assign rdata0  = fmem[0][rptr[0]];
  always @(posedge rclk) rdata1 <= fmem[1][rptr[1]];

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr[0] <= '0;
      rptr[1] <= '0;
    end else begin
      if (rinc0) rptr[0] <= rptr[0] + 5'd1;
      if (rinc1) rptr[1] <= rptr[1] + 5'd1;
    end
  end

  fifo_rd_stream #(.DATASIZE(8), .RD_LATENCY(0)) dut0 (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty0),
    .rdata  (rdata0),
    .rinc   (rinc0),
    .idle   (idle0),
    .m      (s0)
`ifdef FIFO_RD_BEATCNT_EN
    ,
    .beat_cnt     (bc0),
    .beat_cnt_clr (clr)
`endif
  );

  fifo_rd_stream #(.DATASIZE(8), .RD_LATENCY(1)) dut1 (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty1),
    .rdata  (rdata1),
    .rinc   (rinc1),
    .idle   (idle1),
    .m      (s1)
`ifdef FIFO_RD_BEATCNT_EN
    ,
    .beat_cnt     (bc1),
    .beat_cnt_clr (clr)
`endif
  );

`ifndef FIFO_RD_BEATCNT_EN
  assign bc0 = '0;
  assign bc1 = '0;
`endif

  function automatic logic f_mv(input int l);
    return (l == 0) ? s0.m_valid : s1.m_valid;
  endfunction

  function automatic logic [7:0] f_md(input int l);
    return (l == 0) ? s0.m_data : s1.m_data;
  endfunction

  function automatic logic f_rinc(input int l);
    return (l == 0) ? rinc0 : rinc1;
  endfunction

  function automatic logic f_idle(input int l);
    return (l == 0) ? idle0 : idle1;
  endfunction

  function automatic logic [1:0] f_cnt(input int l);
    return (l == 0) ? dut0.u_skid.count : dut1.u_skid.count;
  endfunction

  // the buffer may never hold more than two beats
  always @(negedge rclk) begin
    if (rrst_n === 1'b1) begin
      n_checks++;
      if (dut0.u_skid.count > 2'd2 || dut1.u_skid.count > 2'd2) begin
        $display("FAIL overflow: count0=%0d count1=%0d, required <= 2",
                 dut0.u_skid.count, dut1.u_skid.count);
        n_fail++;
      end
    end
  end

  task automatic load(input int l, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[l][wptr[l] + 5'(i)] = base + 8'(i);
    end
    wptr[l] = wptr[l] + 5'(n);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n  = 1'b0;
    rdy     = 2'b00;
    clr     = 1'b0;
    wptr[0] = '0;
    wptr[1] = '0;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge rclk);
    rrst_n  = 1'b0;
    wptr[0] = 5'd3;
    wptr[1] = 5'd3;
    @(negedge rclk);
    #1;
    for (int l = 0; l < 2; l++) begin
      n_checks++;
      if ({f_rinc(l), f_mv(l), f_md(l), f_idle(l), f_cnt(l)} !== {1'b0, 1'b0, 8'h00, 1'b0, 2'd0}) begin
        $display("FAIL reset_state l=%0d: rinc=%b valid=%b data=%h idle=%b count=%0d, required 0 0 00 0 0",
                 l, f_rinc(l), f_mv(l), f_md(l), f_idle(l), f_cnt(l));
        n_fail++;
      end
    end
    n_checks++;
    if (dut1.inflight !== 1'b0) begin
      $display("FAIL reset_inflight: got %b, required 0", dut1.inflight);
      n_fail++;
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    n_checks++;
    if ({rinc0, rinc1} !== 2'b11) begin
      $display("FAIL reset_release_rinc: rinc0=%b rinc1=%b, required 1 1", rinc0, rinc1);
      n_fail++;
    end
    do_reset();
  endtask

  task automatic test_stream(input int l);
    do_reset();
    rdy = 2'b11;
    load(l, 8, 8'h10);
    #1;
    n_checks++;
    if ({f_rinc(l), f_mv(l)} !== 2'b10) begin
      $display("FAIL stream_first_rinc l=%0d: rinc=%b valid=%b, required rinc=1 valid=0", l, f_rinc(l), f_mv(l));
      n_fail++;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge rclk);
      #1;
      n_checks++;
      if (c < 1 + l) begin
        if (f_mv(l) !== 1'b0) begin
          $display("FAIL stream_latency l=%0d c=%0d: valid=%b, required 0", l, c, f_mv(l));
          n_fail++;
        end
      end else if (c <= 8 + l) begin
        if ({f_mv(l), f_md(l)} !== {1'b1, 8'h10 + 8'(c - 1 - l)}) begin
          $display("FAIL stream_data l=%0d c=%0d: valid=%b data=%h, required valid=1 data=%h",
                   l, c, f_mv(l), f_md(l), 8'h10 + 8'(c - 1 - l));
          n_fail++;
        end
      end else begin
        if ({f_mv(l), f_idle(l)} !== 2'b01) begin
          $display("FAIL stream_idle l=%0d c=%0d: valid=%b idle=%b, required valid=0 idle=1", l, c, f_mv(l), f_idle(l));
          n_fail++;
        end
      end
      if (c == 8 + l) begin
        n_checks++;
        if (f_rinc(l) !== 1'b0) begin
          $display("FAIL stream_rinc_empty l=%0d: rinc=%b, required 0", l, f_rinc(l));
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_back_pressure(input int l);
    logic [7:0] exp_d;
    int         got;
    do_reset();
    load(l, 8, 8'h20);
    exp_d = 8'h20;
    got   = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      rdy[l] = !(c >= 4 && c <= 8);
      #1;
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if ({f_mv(l), f_md(l)} !== {1'b1, exp_d}) begin
          $display("FAIL bp_hold l=%0d c=%0d: valid=%b data=%h, required valid=1 data=%h", l, c, f_mv(l), f_md(l), exp_d);
          n_fail++;
        end
        if (c >= 5) begin
          n_checks++;
          if ({f_cnt(l), f_rinc(l)} !== {2'd2, 1'b0}) begin
            $display("FAIL bp_full l=%0d c=%0d: count=%0d rinc=%b, required count=2 rinc=0", l, c, f_cnt(l), f_rinc(l));
            n_fail++;
          end
        end
      end else if (f_mv(l)) begin
        n_checks++;
        if (f_md(l) !== exp_d) begin
          $display("FAIL bp_data l=%0d c=%0d: data=%h, required %h", l, c, f_md(l), exp_d);
          n_fail++;
        end
        exp_d = exp_d + 8'd1;
        got++;
      end
      @(negedge rclk);
    end
    #1;
    n_checks++;
    if (got != 8 || f_mv(l) !== 1'b0 || f_idle(l) !== 1'b1) begin
      $display("FAIL bp_drain l=%0d: beats=%0d valid=%b idle=%b, required beats=8 valid=0 idle=1", l, got, f_mv(l), f_idle(l));
      n_fail++;
    end
  endtask

  task automatic test_empty_boundary(input int l);
    int pulses;
    int beats;
    do_reset();
    rdy = 2'b11;
    load(l, 1, 8'hA5);
    pulses = 0;
    beats  = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (f_rinc(l)) pulses++;
      if (f_mv(l)) begin
        beats++;
        n_checks++;
        if (f_md(l) !== 8'hA5) begin
          $display("FAIL empty_data l=%0d: data=%h, required a5", l, f_md(l));
          n_fail++;
        end
      end
      @(negedge rclk);
    end
    #1;
    n_checks++;
    if (pulses != 1 || beats != 1 || f_idle(l) !== 1'b1 || f_rinc(l) !== 1'b0) begin
      $display("FAIL empty_boundary l=%0d: pulses=%0d beats=%0d idle=%b rinc=%b, required 1 1 1 0",
               l, pulses, beats, f_idle(l), f_rinc(l));
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy = 2'b11;
    load(1, 8, 8'h40);
    repeat (3) @(negedge rclk);
    #1;
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if ({s1.m_valid, s1.m_data, rinc1, dut1.inflight, dut1.u_skid.count} !== {1'b0, 8'h00, 1'b0, 1'b0, 2'd0}) begin
      $display("FAIL reset_mid: valid=%b data=%h rinc=%b inflight=%b count=%0d, required 0 00 0 0 0",
               s1.m_valid, s1.m_data, rinc1, dut1.inflight, dut1.u_skid.count);
      n_fail++;
    end
    do_reset();
    #1;
    n_checks++;
    if ({s1.m_valid, idle1} !== 2'b01) begin
      $display("FAIL reset_mid_idle: valid=%b idle=%b, required valid=0 idle=1", s1.m_valid, idle1);
      n_fail++;
    end
  endtask

`ifdef FIFO_RD_BEATCNT_EN
  task automatic test_beat_cnt();
    int pops;
    do_reset();
    rdy  = 2'b01;
    pops = 0;
    for (int c = 0; c < 400 && pops < 300; c++) begin
      wptr[0] = rptr[0] + 5'd4;
      #1;
      if (s0.m_valid) pops++;
      @(negedge rclk);
    end
    rdy[0] = 1'b0;
    #1;
    n_checks++;
    if (bc0 !== 32'd300) begin
      $display("FAIL beat_cnt_300: got %0d, required 300", bc0);
      n_fail++;
    end
    rdy[0] = 1'b1;
    clr    = 1'b1;
    #1;
    n_checks++;
    if (s0.m_valid !== 1'b1) begin
      $display("FAIL beat_cnt_clr_pop_valid: valid=%b, required 1", s0.m_valid);
      n_fail++;
    end
    @(negedge rclk);
    clr = 1'b0;
    #1;
    n_checks++;
    if (bc0 !== 32'd0) begin
      $display("FAIL beat_cnt_clr: got %0d, required 0", bc0);
      n_fail++;
    end
    @(negedge rclk);
    rdy[0] = 1'b0;
    #1;
    n_checks++;
    if (bc0 !== 32'd1) begin
      $display("FAIL beat_cnt_after_clr: got %0d, required 1", bc0);
      n_fail++;
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) fmem[k][i] = '0;
      wptr[k] = '0;
    end
    test_reset();
    test_stream(0);
    test_stream(1);
    test_back_pressure(0);
    test_back_pressure(1);
    test_empty_boundary(0);
    test_empty_boundary(1);
    test_reset_mid();
`ifdef FIFO_RD_BEATCNT_EN
    test_beat_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
